// File: rtl/mux9_frame_scanner_pkg.sv
// Shared constants and state type for the 9-slot selector frame scanner.
package mux9_frame_scanner_pkg;

  localparam int unsigned NSLOT     = 9;
  localparam int unsigned W         = 4;
  localparam int unsigned LAST_SLOT = NSLOT - 1;
  localparam int unsigned FRAME_W   = NSLOT * W;

  typedef enum logic {
    StIdle,
    StScan
  } state_e;

endpackage

// File: rtl/mux9_frame_scanner_if.sv
// Control, selector and frame signals between a scanner and its user/selector.
interface mux9_frame_scanner_if;
  import mux9_frame_scanner_pkg::*;

  logic               start;
  logic               abort;
  logic               cont;
  logic [W-1:0]       y_in;
  logic [W-1:0]       sel;
  logic               busy;
  logic               done;
  logic               frame_valid;
  logic [FRAME_W-1:0] frame_out;

  modport master (
    output start, abort, cont, y_in,
    input  sel, busy, done, frame_valid, frame_out
  );

  modport slave (
    input  start, abort, cont, y_in,
    output sel, busy, done, frame_valid, frame_out
  );

endinterface

// File: rtl/mux9_dwell_cnt.sv
// Per-slot dwell counter; tick_o marks the last cycle of a slot's dwell.
module mux9_dwell_cnt #(
  parameter int unsigned DWELL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [7:0] CntLast = 8'(DWELL - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CntLast);
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux9_frame_scanner.sv
// Steps a 9:1 selector through all slots and packs the sampled nibbles into one frame.
module mux9_frame_scanner
  import mux9_frame_scanner_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input logic                  clk,
  input logic                  rst,
  mux9_frame_scanner_if.slave  bus
);

  localparam logic [W-1:0] SelLast = W'(LAST_SLOT);
  localparam logic [W-1:0] SelOne  = W'(1);

  state_e             state_q;
  logic [W-1:0]       sel_q;
  logic [FRAME_W-1:0] shadow_q;
  logic [FRAME_W-1:0] frame_q;
  logic               busy_q, done_q, valid_q;
  logic               tick;
  logic [FRAME_W-1:0] shadow_merged;

  mux9_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  ((state_q == StIdle) || bus.abort),
    .en_i   (state_q == StScan),
    .tick_o (tick)
  );

  // Current sample folded in, so the final nibble reaches frame_out on the capture edge.
  always_comb begin
    shadow_merged = shadow_q;
    shadow_merged[int'(sel_q) * W +: W] = bus.y_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          sel_q  <= '0;
          busy_q <= 1'b0;
          if (bus.start && !bus.abort) begin
            state_q  <= StScan;
            busy_q   <= 1'b1;
            shadow_q <= '0;
          end
        end
        StScan: begin
          if (bus.abort) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            shadow_q <= '0;
          end else if (tick) begin
            shadow_q <= shadow_merged;
            if (sel_q == SelLast) begin
              frame_q <= shadow_merged;
              done_q  <= 1'b1;
              valid_q <= 1'b1;
              sel_q   <= '0;
              if (!bus.cont) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end
            end else begin
              sel_q <= sel_q + SelOne;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sel         = sel_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_out   = frame_q;

endmodule
